nios2system_input_pio: RTL and testbench

NIOS2SYSTEM_INPUT_PIO -- requirements
Module: nios2system_input_pio

---
 rtl/nios2system_input_pio.sv | 188 ++++++++++++++++++
 tb/tb_nios2system_input_pio.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2system_input_pio.sv
// -----------------------------------------------------------------------------
// nios2system_input_pio
//
// Avalon-MM input PIO for switches/buttons.  Each in_port bit is synchronised,
// debounced, and edge-detected; detected edges latch into edge_capture and can
// raise a level interrupt through irq_mask.
//
// Parameters
//   WIDTH           input width (1..32)
//   SYNC_STAGES     synchroniser depth per bit (2..4)
//   DEBOUNCE_CYCLES consecutive differing cycles needed to accept a level;
//                   0 bypasses the debouncer (debounced level = synchroniser out)
//   EDGE_TYPE       0 rising, 1 falling, 2 any edge
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata         Avalon-MM slave write side
//   in_port                    asynchronous external inputs
//   readdata                   registered read data (latency 1, ignores chipselect)
//   irq                        registered OR of (edge_capture & irq_mask)
//
// Register map
//   0 data (debounced level, read only)   1 irq_mask (r/w)
//   2 reserved, reads 0                    3 edge_capture (read, write-1-to-clear)
// -----------------------------------------------------------------------------
module nios2system_input_pio #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // ---------------------------------------------------------------- sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    logic [WIDTH-1:0] s;       // synchronised input
    logic [WIDTH-1:0] deb;     // current debounced level
    logic [WIDTH-1:0] deb_nx;  // debounced level after this clock edge

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------ debounce
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // The last synchroniser flop is the debounced level, so the
            // end-to-end latency stays at SYNC_STAGES edges and the edge
            // detector looks one stage upstream to see the next value.
            assign deb    = s;
            assign deb_nx = sync_q[SYNC_STAGES-2];
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0] deb_q, deb_d;
            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];

            // cnt counts how many previous edges s has disagreed with deb;
            // the level is accepted on the DEBOUNCE_CYCLES-th disagreeing edge.
            always_comb begin
                deb_d = deb_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = cnt_q[i];
                    if (s[i] == deb_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_TC) begin
                        deb_d[i] = s[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    deb_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    deb_q <= deb_d;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign deb    = deb_q;
            assign deb_nx = deb_d;
        end
    endgenerate

    // --------------------------------------------------------- edge detect
    logic [WIDTH-1:0] edge_evt;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_evt = deb_nx & ~deb;
            1:       edge_evt = ~deb_nx & deb;
            default: edge_evt = deb_nx ^ deb;
        endcase
    end

    // ----------------------------------------------------------- registers
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;

    always_comb begin
        wr_en          = chipselect & ~write_n;
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;

        if (wr_en && address == 2'd1) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
        end
        // Setting after clearing lets a coincident edge event win.
        edge_capture_d = edge_capture_d | edge_evt;

        case (address)
            2'd0:    readdata_d = 32'(deb);
            2'd1:    readdata_d = 32'(irq_mask_q);
            2'd3:    readdata_d = 32'(edge_capture_q);
            default: readdata_d = '0;
        endcase

        irq_d = |(edge_capture_q & irq_mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

    // writedata bits above WIDTH have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios2system_input_pio.sv
// -----------------------------------------------------------------------------
// Bench for nios2system_input_pio.
//   dut   : default parameters (WIDTH 10, 2 sync stages, debounce 4, rising)
//   dut_w : WIDTH 32, debounce bypassed, any-edge capture
// The default instance is tracked every cycle by a reference model built from
// the input history: a new level is accepted once the synchronised input has
// disagreed with the debounced level on the last DEBOUNCE_CYCLES edges.
// -----------------------------------------------------------------------------
module tb_nios2system_input_pio;

    localparam int W = 10;
    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0] in_port_w = '0;
    logic [31:0] readdata, readdata_w;
    logic        irq, irq_w;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    nios2system_input_pio #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios2system_input_pio #(
        .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
    ) dut_w (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_w),
        .readdata(readdata_w), .irq(irq_w)
    );

    // ------------------------------------------------------ reference model
    bit [W-1:0] inq [$];     // in_port samples still inside the synchroniser
    bit [W-1:0] shist [$];   // last D synchronised values seen before an edge
    bit [W-1:0] deb_m, mask_m, cap_m;
    bit [31:0]  rd_m;
    bit         irq_m;

    always @(posedge clk) begin
        bit [W-1:0] s_pre, new_deb;
        bit [31:0]  rd_new;
        bit         irq_new, all_diff;
        if (reset) begin
            inq = {};
            for (int k = 0; k < S; k++) inq.push_back('0);
            shist  = {};
            deb_m  = '0;
            mask_m = '0;
            cap_m  = '0;
            rd_m   = '0;
            irq_m  = 1'b0;
        end else begin
            case (address)
                2'd0:    rd_new = 32'(deb_m);
                2'd1:    rd_new = 32'(mask_m);
                2'd3:    rd_new = 32'(cap_m);
                default: rd_new = '0;
            endcase
            irq_new = (cap_m & mask_m) != '0;

            s_pre = inq[0];
            void'(inq.pop_front());
            inq.push_back(in_port);
            shist.push_back(s_pre);
            if (shist.size() > D) void'(shist.pop_front());

            new_deb = deb_m;
            if (shist.size() == D) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (shist[j]) if (shist[j][b] == deb_m[b]) all_diff = 1'b0;
                    if (all_diff) new_deb[b] = ~deb_m[b];
                end
            end

            if (chipselect && !write_n && address == 2'd1) mask_m = writedata[W-1:0];
            if (chipselect && !write_n && address == 2'd3) cap_m = cap_m & ~writedata[W-1:0];
            cap_m = cap_m | (new_deb & ~deb_m);
            deb_m = new_deb;
            rd_m  = rd_new;
            irq_m = irq_new;
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle(input logic [1:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_port   = '0;
        in_port_w = '0;
        bus_idle(2'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // --------------------------------------------------------- vector table
    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // register-map vectors, in_port held 0; exp_rd is readdata after the edge
        tbl[0]  = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h000, 1'b0};
        tbl[1]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h3FF, 1'b0};
        tbl[2]  = '{2'd0, 1'b1, 1'b0, 32'h155,       32'h000, 1'b0};
        tbl[3]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h3FF, 1'b0};
        tbl[4]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h000, 1'b0};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h000, 1'b0};
        tbl[6]  = '{2'd1, 1'b0, 1'b0, 32'h204,       32'h3FF, 1'b0};
        tbl[7]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h3FF, 1'b0};
        tbl[8]  = '{2'd1, 1'b1, 1'b0, 32'hABCD_E125, 32'h3FF, 1'b0};
        tbl[9]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h125, 1'b0};
        tbl[10] = '{2'd1, 1'b1, 1'b1, 32'h0,         32'h125, 1'b0};
        tbl[11] = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h125, 1'b0};
        tbl[12] = '{2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h000, 1'b0};
        tbl[13] = '{2'd1, 1'b1, 1'b0, 32'h0,         32'h125, 1'b0};
        tbl[14] = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h000, 1'b0};

        @(negedge clk);
        tick();
        #1;
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 15; v++) begin
            address    = tbl[v].addr;
            chipselect = tbl[v].cs;
            write_n    = tbl[v].wn;
            writedata  = tbl[v].wd;
            tick();
            chk($sformatf("table%0d_rd", v), readdata, tbl[v].exp_rd);
            chk($sformatf("table%0d_irq", v), {31'h0, irq}, {31'h0, tbl[v].exp_irq});
        end

        // ---- stable rise on bit 0: deb changes on edge 6, readdata one edge later
        do_reset();
        in_port = 10'h001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("rise0_data_e%0d", e), readdata, (e >= 7) ? 32'h1 : 32'h0);
        end
        address = 2'd3;
        tick();
        chk("rise0_capture", readdata, 32'h1);
        chk("rise0_irq_masked", {31'h0, irq}, 32'h0);

        // ---- 3-cycle glitch on bit 3 is rejected
        do_reset();
        in_port = 10'h008;
        tick(); tick(); tick();
        in_port = '0;
        for (int e = 0; e < 10; e++) tick();
        chk("glitch_data", readdata, 32'h0);
        address = 2'd3;
        tick();
        chk("glitch_capture", readdata, 32'h0);

        // ---- masked capture on bit 2 raises irq, clear drops it
        do_reset();
        bus_write(2'd1, 32'h4);
        tick();
        bus_idle(2'd3);
        in_port = 10'h004;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e >= 6) chk($sformatf("irq_rise_e%0d", e), {31'h0, irq}, (e >= 7) ? 32'h1 : 32'h0);
        end
        bus_write(2'd3, 32'h4);
        tick();
        chk("irq_clear_same_edge", {31'h0, irq}, 32'h1);
        bus_idle(2'd3);
        tick();
        chk("irq_clear_next", {31'h0, irq}, 32'h0);
        chk("irq_clear_capture", readdata, 32'h0);

        // ---- edge on bit 1 coincident with its clear: set wins
        do_reset();
        in_port = 10'h002;
        for (int e = 1; e <= 5; e++) tick();
        bus_write(2'd3, 32'h2);
        tick();
        bus_idle(2'd3);
        tick();
        chk("set_wins_capture", readdata, 32'h2);
        bus_write(2'd3, 32'h2);
        tick();
        bus_idle(2'd3);
        tick();
        chk("later_clear_capture", readdata, 32'h0);

        // ---- reset mid-debounce discards the count
        do_reset();
        bus_write(2'd1, 32'h3FF);
        in_port = 10'h001;
        tick();
        bus_idle(2'd1);
        tick(); tick(); tick();
        chk("pre_reset_mask", readdata, 32'h3FF);
        reset = 1'b1;
        #1;
        chk("async_reset_rd", readdata, 32'h0);
        chk("async_reset_irq", {31'h0, irq}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        bus_idle(2'd0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e >= 6) chk($sformatf("restart_data_e%0d", e), readdata, (e >= 7) ? 32'h1 : 32'h0);
        end
        address = 2'd3;
        tick();
        chk("restart_capture", readdata, 32'h1);

        // ---- wide any-edge instance, debounce bypassed
        do_reset();
        bus_idle(2'd3);
        in_port_w = 32'h8000_0000;
        for (int e = 1; e <= 3; e++) tick();
        chk("wide_rise_capture", readdata_w, 32'h8000_0000);
        bus_write(2'd3, 32'hFFFF_FFFF);
        tick();
        bus_idle(2'd3);
        tick();
        chk("wide_cleared", readdata_w, 32'h0);
        in_port_w = 32'h0;
        tick(); tick();
        chk("wide_fall_e2_rd", readdata_w, 32'h0);
        tick();
        chk("wide_fall_capture", readdata_w, 32'h8000_0000);
        chk("wide_irq", {31'h0, irq_w}, 32'h0);
        bus_idle(2'd0);
        tick();
        chk("wide_data", readdata_w, 32'h0);

        // ---- randomized traffic against the model
        in_port_w = '0;
        for (int c = 0; c < 3000; c++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
            end
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 1);
            writedata  = $urandom;
            tick();
            chk($sformatf("rand%0d_rd", c), readdata, rd_m);
            chk($sformatf("rand%0d_irq", c), {31'h0, irq}, {31'h0, irq_m});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
